// File: rtl/instr_fetch.sv
// instr_fetch: sequential fetch address generator, instruction-memory handshake,
// and a small prefetch FIFO of {instruction, pc} presented to the decoder.
// Optional feature macro: MISALIGN_TRAP_EN. When defined, a misaligned redirect
// target parks the stage in HALT with fetchMisaligned set. When undefined, the
// low two target bits are ignored.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imemAddr,
  output logic        imemReq,
  input  logic        imemAck,
  input  logic [31:0] imemRdata,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        instrValid,
  input  logic        instrReady,
  input  logic        redirect,
  input  logic [31:0] redirectPC,
  output logic        fetchMisaligned
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [31:0]        fetch_pc_q;
  logic [31:0]        fetch_pc_d;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [31:0]        instr_mem [FIFO_DEPTH];
  logic [31:0]        pc_mem    [FIFO_DEPTH];
  logic               req;
  logic               push;
  logic               pop;
  logic               not_full;

  assign not_full = (count_q < CNT_W'(FIFO_DEPTH));

`ifdef MISALIGN_TRAP_EN
  logic mis_q;
  logic mis_d;
`else
  // The low target bits have no meaning when misaligned targets are not trapped.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirectPC[1:0];
`endif

  // State and fetch PC register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Next-state, next fetch PC and request/handshake decode
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req        = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis_d      = mis_q;
`endif

    if ((state_q == RUN) && not_full && !reset) begin
      req = 1'b1;
    end
    pop  = (count_q != '0) && instrReady;
    push = req && imemAck && !redirect;

    if (redirect) begin
`ifdef MISALIGN_TRAP_EN
      fetch_pc_d = redirectPC;
      if (redirectPC[1:0] != 2'b00) begin
        state_d = HALT;
        mis_d   = 1'b1;
      end else begin
        state_d = RUN;
        mis_d   = 1'b0;
      end
`else
      fetch_pc_d = {redirectPC[31:2], 2'b00};
      state_d    = RUN;
`endif
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

`ifdef MISALIGN_TRAP_EN
  // Sticky misaligned-target flag, cleared by aligned redirect or reset
  always_ff @(posedge clk) begin
    if (reset) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
    end
  end

  assign fetchMisaligned = mis_q;
`else
  assign fetchMisaligned = 1'b0;
`endif

  // FIFO pointers and occupancy; redirect flushes everything still buffered
  always_ff @(posedge clk) begin
    if (reset || redirect) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; push is already masked by reset and redirect
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= imemRdata;
      pc_mem[wr_ptr_q]    <= {fetch_pc_q[31:2], 2'b00};
    end
  end

  assign imemReq     = req;
  assign imemAddr    = {fetch_pc_q[31:2], 2'b00};
  assign instrValid  = (count_q != '0);
  assign instruction = instr_mem[rd_ptr_q];
  assign pc          = pc_mem[rd_ptr_q];

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed sequence with a scoreboard of expected
// {pc, instruction} pairs pushed on each accepted fetch and checked on delivery.
module tb_instr_fetch;

  localparam logic [31:0] KEY = 32'h5A5A_0F0F;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_mis;

  logic [31:0] addr2;
  logic        req2;
  logic        ack2;
  logic [31:0] rdata2;
  logic [31:0] instr2;
  logic [31:0] pc2;
  logic        valid2;
  logic        ready2;
  logic        redirect2;
  logic [31:0] redirect_pc2;
  logic        mis2;

  int tests = 0;
  int fails = 0;

  logic [31:0] q_pc[$];
  logic [31:0] delivered[$];
  logic [31:0] model_pc;
  logic        model_halt;
  logic        model_mis;

  // Memory model: data word is a fixed function of the address
  assign imem_rdata = imem_addr ^ KEY;
  assign rdata2     = addr2 ^ KEY;

  instr_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .imemAddr(imem_addr), .imemReq(imem_req),
    .imemAck(imem_ack), .imemRdata(imem_rdata), .instruction(instruction),
    .pc(pc), .instrValid(instr_valid), .instrReady(instr_ready),
    .redirect(redirect), .redirectPC(redirect_pc), .fetchMisaligned(fetch_mis)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
    .clk(clk), .reset(reset), .imemAddr(addr2), .imemReq(req2),
    .imemAck(ack2), .imemRdata(rdata2), .instruction(instr2),
    .pc(pc2), .instrValid(valid2), .instrReady(ready2),
    .redirect(redirect2), .redirectPC(redirect_pc2), .fetchMisaligned(mis2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model, advance the model, take the edge
  task automatic cyc();
    logic exp_req;
    #1;
    exp_req = !reset && !model_halt && (q_pc.size() < 2);
    if (!reset) begin
      chk1("instr_valid", instr_valid, q_pc.size() != 0);
      chk1("imem_req", imem_req, exp_req);
      chk1("fetch_misaligned", fetch_mis, model_mis);
      if (q_pc.size() != 0) begin
        chk32("head_pc", pc, q_pc[0]);
        chk32("head_instruction", instruction, q_pc[0] ^ KEY);
      end
      if (exp_req) chk32("imem_addr", imem_addr, model_pc);
    end
    if (reset) begin
      q_pc.delete();
      model_pc   = 32'h0000_0000;
      model_halt = 1'b0;
      model_mis  = 1'b0;
    end else begin
      if ((q_pc.size() != 0) && instr_ready) begin
        delivered.push_back(q_pc[0]);
        void'(q_pc.pop_front());
      end
      if (redirect) begin
        q_pc.delete();
`ifdef MISALIGN_TRAP_EN
        model_pc   = redirect_pc;
        model_mis  = (redirect_pc[1:0] != 2'b00);
        model_halt = model_mis;
`else
        model_pc = {redirect_pc[31:2], 2'b00};
`endif
      end else if (exp_req && imem_ack) begin
        q_pc.push_back(model_pc);
        model_pc = model_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int mark;
    int eights;
    reset        = 1'b1;
    imem_ack     = 1'b0;
    instr_ready  = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = 32'h0;
    ack2         = 1'b1;
    ready2       = 1'b1;
    redirect2    = 1'b0;
    redirect_pc2 = 32'h0;
    model_pc     = 32'h0;
    model_halt   = 1'b0;
    model_mis    = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk1("rst_valid", instr_valid, 1'b0);
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_mis", fetch_mis, 1'b0);
    chk32("rst_addr", imem_addr, 32'h0000_0000);
    chk32("rst_addr_wrap", addr2, 32'hFFFF_FFF8);

    // Streaming: ack every cycle, decoder always ready
    reset       = 1'b0;
    imem_ack    = 1'b1;
    instr_ready = 1'b1;
    chk32("wrap_addr0", addr2, 32'hFFFF_FFF8);
    cyc();
    chk32("wrap_addr1", addr2, 32'hFFFF_FFFC);
    chk32("wrap_pc0", pc2, 32'hFFFF_FFF8);
    chk32("wrap_instr0", instr2, 32'hFFFF_FFF8 ^ KEY);
    chk1("wrap_valid0", valid2, 1'b1);
    chk1("wrap_req", req2, 1'b1);
    chk1("wrap_mis", mis2, 1'b0);
    cyc();
    chk32("wrap_addr2", addr2, 32'h0000_0000);
    repeat (4) cyc();
    chk32("stream_pc0", delivered[0], 32'h0);
    chk32("stream_pc1", delivered[1], 32'h4);
    chk32("stream_pc2", delivered[2], 32'h8);
    chk32("stream_pc3", delivered[3], 32'hC);

    // Backpressure: FIFO fills, request drops, no loss on resume
    instr_ready = 1'b0;
    repeat (4) cyc();
    chk1("full_req_low", imem_req, 1'b0);
    chk1("full_valid", instr_valid, 1'b1);
    instr_ready = 1'b1;
    repeat (6) cyc();

    // Redirect to 0x100 in the cycle 0x8 is acked
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    mark  = delivered.size();
    cyc();
    cyc();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    cyc();
    redirect = 1'b0;
    chk32("redir_addr", imem_addr, 32'h0000_0100);
    chk1("redir_valid", instr_valid, 1'b0);
    repeat (4) cyc();
    eights = 0;
    for (int i = mark; i < delivered.size(); i++) if (delivered[i] == 32'h8) eights++;
    chk32("redir_no_0x8", 32'(eights), 32'd0);
    chk32("redir_seq0", delivered[mark], 32'h0);
    chk32("redir_seq1", delivered[mark+1], 32'h4);
    chk32("redir_seq2", delivered[mark+2], 32'h100);

    // Redirect with pop of head 0x4 while 0x8 is buffered
    reset = 1'b1;
    cyc();
    reset       = 1'b0;
    mark        = delivered.size();
    instr_ready = 1'b0;
    cyc();
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    cyc();
    chk1("pop_redir_full", imem_req, 1'b0);
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    cyc();
    redirect = 1'b0;
    chk32("pop_redir_addr", imem_addr, 32'h0000_0200);
    chk1("pop_redir_valid", instr_valid, 1'b0);
    repeat (4) cyc();
    chk32("pop_redir_seq0", delivered[mark], 32'h0);
    chk32("pop_redir_seq1", delivered[mark+1], 32'h4);
    chk32("pop_redir_seq2", delivered[mark+2], 32'h200);

    // Misaligned redirect target
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0102;
    cyc();
    redirect = 1'b0;
`ifdef MISALIGN_TRAP_EN
    chk1("mis_flag", fetch_mis, 1'b1);
    chk1("mis_req", imem_req, 1'b0);
`else
    chk32("mis_addr", imem_addr, 32'h0000_0100);
    chk1("mis_flag", fetch_mis, 1'b0);
`endif
    repeat (3) cyc();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    cyc();
    redirect = 1'b0;
    chk1("realign_req", imem_req, 1'b1);
    chk1("realign_mis", fetch_mis, 1'b0);
    chk32("realign_addr", imem_addr, 32'h0000_0200);
    repeat (4) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
